mem_port_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline MEM stage (port A, issuing the registered read/write strobes and ALU result as address) and a secondary bus master (port B, loader/DMA). Grants at most one transfer per arbitration, serialises fixed-latency reads, stalls the pipeline while MEM-stage accesses are outstanding, and guarantees bounded-latency service for port B. Sits between the MEM pipeline register and the data RAM.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default parameters for the data-memory port arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;
  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_MAX_STARVE = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the MEM stage (A) and a bus master (B)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_rmem,
  input  logic          a_wmem,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_stall,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_t     r_state, w_state_nx;
  owner_t     r_own, w_own_nx;
  logic [2:0] r_lat, w_lat_nx;
  logic [3:0] r_starve, w_starve_nx;
  logic       w_idle, w_a_req, w_starved, w_a_win, w_b_win, w_we, w_rd, w_done;
  assign w_idle    = r_state == IDLE;
  assign w_a_req   = a_rmem | a_wmem;
  assign w_starved = r_starve == 4'(MAX_STARVE);
  assign w_b_win   = w_idle & b_req & (~w_a_req | w_starved);
  assign w_a_win   = w_idle & w_a_req & ~w_b_win;
  // a_wmem dominates a_rmem when both are set
  assign w_we      = w_a_win ? a_wmem : (w_b_win & b_we);
  assign w_rd      = (w_a_win | w_b_win) & ~w_we;
  // lat_cnt holds RD_LAT on the first wait cycle, so 1 marks the data cycle
  assign w_done    = (r_state == RD_WAIT) & (r_lat == 3'd1);
  always_comb begin
    w_state_nx  = r_state;
    w_own_nx    = r_own;
    w_lat_nx    = r_lat;
    if (w_rd) begin
      w_state_nx = RD_WAIT;
      w_own_nx   = w_b_win ? OWN_B : OWN_A;
      w_lat_nx   = 3'(RD_LAT);
    end else if (r_state == RD_WAIT) begin
      w_lat_nx   = r_lat - 3'd1;
      w_state_nx = w_done ? IDLE : RD_WAIT;
    end
    w_starve_nx = (w_b_win | ~b_req) ? 4'd0 :
                  (w_a_win & ~w_starved) ? r_starve + 4'd1 : r_starve;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_own    <= OWN_A;
      r_lat    <= 3'd0;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_own    <= w_own_nx;
      r_lat    <= w_lat_nx;
      r_starve <= w_starve_nx;
    end
  end
  assign mem_re    = w_rd;
  assign mem_we    = w_we;
  assign mem_addr  = w_a_win ? a_addr : w_b_win ? b_addr : '0;
  assign mem_wdata = w_a_win ? a_wdata : w_b_win ? b_wdata : '0;
  assign b_gnt     = w_b_win;
  assign a_rvalid  = w_done & (r_own == OWN_A);
  assign b_rvalid  = w_done & (r_own == OWN_B);
  assign a_rdata   = a_rvalid ? mem_rdata : '0;
  assign b_rdata   = b_rvalid ? mem_rdata : '0;
  assign a_stall   = w_a_req & ~((w_a_win & a_wmem) | a_rvalid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, read latency, starvation and reset abandon
module tb_mem_port_arbiter;
  logic        clk = 0;
  logic        rst, a_rmem, a_wmem, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, mem_rdata;
  logic        a_stall, a_rvalid, b_gnt, b_rvalid, mem_re, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
  logic        c_stall, c_arv, c_gnt, c_brv, c_re, c_we;
  logic [31:0] c_ard, c_brd, c_addr, c_wdata;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_STARVE(4)) u_dut (
    .clk(clk), .rst(rst), .a_rmem(a_rmem), .a_wmem(a_wmem), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_stall(a_stall), .a_rdata(a_rdata), .a_rvalid(a_rvalid), .b_req(b_req), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_STARVE(4)) u_dut3 (
    .clk(clk), .rst(rst), .a_rmem(a_rmem), .a_wmem(a_wmem), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_stall(c_stall), .a_rdata(c_ard), .a_rvalid(c_arv), .b_req(b_req), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(c_gnt), .b_rdata(c_brd), .b_rvalid(c_brv),
    .mem_re(c_re), .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_rdata(mem_rdata));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; a_rmem = 0; a_wmem = 0; b_req = 0; b_we = 0;
    a_addr = 0; a_wdata = 0; b_addr = 0; b_wdata = 0; mem_rdata = 32'hDEADBEEF;
    cyc(); cyc();
    rst = 0;
    cyc(); #2;
    chk("rst_stall", a_stall, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_gnt", b_gnt, 0);
    chk("rst_arv", a_rvalid, 0);
    chk("rst_addr", mem_addr, 0);
    a_rmem = 1; a_addr = 32'h10; #2;
    chk("rd_t_re", mem_re, 1);
    chk("rd_t_addr", mem_addr, 32'h10);
    chk("rd_t_stall", a_stall, 1);
    chk("rd_t_rdata0", a_rdata, 0);
    cyc(); #2;
    chk("rd_t1_stall", a_stall, 1);
    chk("rd_t1_re", mem_re, 0);
    chk("rd_t1_arv", a_rvalid, 0);
    cyc(); #2;
    chk("rd_t2_arv", a_rvalid, 1);
    chk("rd_t2_rdata", a_rdata, 32'hDEADBEEF);
    chk("rd_t2_stall", a_stall, 0);
    chk("rd_t2_re", mem_re, 0);
    cyc();
    a_rmem = 0; a_wmem = 1; a_addr = 32'h20; a_wdata = 32'h55; #2;
    chk("wr_we", mem_we, 1);
    chk("wr_re", mem_re, 0);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_wdata", mem_wdata, 32'h55);
    chk("wr_stall", a_stall, 0);
    cyc();
    a_rmem = 1; a_wmem = 1; a_addr = 32'h30; a_wdata = 32'h77; #2;
    chk("rw_we", mem_we, 1);
    chk("rw_re", mem_re, 0);
    chk("rw_stall", a_stall, 0);
    cyc();
    a_rmem = 0; a_wmem = 0; #2;
    chk("rw_arv1", a_rvalid, 0);
    cyc(); #2;
    chk("rw_arv2", a_rvalid, 0);
    cyc();
    mem_rdata = 32'h12345678;
    a_rmem = 1; a_addr = 32'h100; b_req = 1; b_we = 0; b_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      logic eb;
      eb = (g % 5) == 4;
      #2;
      chk($sformatf("st%0d_gnt", g), b_gnt, eb);
      chk($sformatf("st%0d_re", g), mem_re, 1);
      chk($sformatf("st%0d_addr", g), mem_addr, eb ? 32'h200 : 32'h100);
      cyc(); cyc(); #2;
      chk($sformatf("st%0d_arv", g), a_rvalid, !eb);
      chk($sformatf("st%0d_brv", g), b_rvalid, eb);
      chk($sformatf("st%0d_brd", g), b_rdata, eb ? 32'h12345678 : 32'h0);
      chk($sformatf("st%0d_stall", g), a_stall, eb);
      cyc();
    end
    a_rmem = 0; b_req = 0;
    cyc();
    b_req = 1; b_we = 0; b_addr = 32'h40; #2;
    chk("bw_gnt", b_gnt, 1);
    chk("bw_re", mem_re, 1);
    chk("bw_addr", mem_addr, 32'h40);
    cyc();
    b_req = 0; a_wmem = 1; a_addr = 32'h50; a_wdata = 32'h99; #2;
    chk("bw_t1_stall", a_stall, 1);
    chk("bw_t1_we", mem_we, 0);
    cyc(); #2;
    chk("bw_t2_brv", b_rvalid, 1);
    chk("bw_t2_stall", a_stall, 1);
    chk("bw_t2_we", mem_we, 0);
    cyc(); #2;
    chk("bw_t3_we", mem_we, 1);
    chk("bw_t3_addr", mem_addr, 32'h50);
    chk("bw_t3_stall", a_stall, 0);
    cyc();
    a_wmem = 0;
    b_req = 1; b_we = 1; b_addr = 32'h44; b_wdata = 32'hAB; #2;
    chk("bwr_gnt", b_gnt, 1);
    chk("bwr_we", mem_we, 1);
    chk("bwr_wdata", mem_wdata, 32'hAB);
    cyc();
    b_req = 0;
    repeat (4) cyc();
    a_rmem = 1; a_addr = 32'h60; #2;
    chk("rs_re", c_re, 1);
    chk("rs_stall", c_stall, 1);
    cyc();
    rst = 1; a_rmem = 0; #2;
    chk("rs_t1_arv", c_arv, 0);
    cyc();
    rst = 0; #2;
    chk("rs_t2_arv", c_arv, 0);
    chk("rs_t2_re", c_re, 0);
    chk("rs_t2_stall", c_stall, 0);
    chk("rs_t2_rdata", c_ard, 0);
    cyc();
    a_rmem = 1; a_addr = 32'h70; #2;
    chk("rs_t3_re", c_re, 1);
    chk("rs_t3_addr", c_addr, 32'h70);
    chk("rs_t3_arv", c_arv, 0);
    cyc(); #2;
    chk("rs_t4_arv", c_arv, 0);
    cyc(); #2;
    chk("rs_t5_arv", c_arv, 0);
    cyc(); #2;
    chk("rs_t6_arv", c_arv, 1);
    chk("rs_t6_rdata", c_ard, 32'h12345678);
    cyc();
    a_rmem = 0;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
